// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit stage: accepts a WIDTH-bit word on valid/ready, shifts it out one bit per clock.
// Optional trailing parity bit and idle gap. Din_ready is held low from accept until the frame (and gap) completes.
module piso_serializer #(
   parameter int WIDTH      = 4,
   parameter int MSB_FIRST  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int GAP_CYCLES = 0
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic [WIDTH-1:0] Din,
   input  logic             Din_valid,
   output logic             Din_ready,
   output logic             Sout,
   output logic             Sout_valid,
   output logic             Frame_start,
   output logic             Busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    count_q, count_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             par_q, par_d;
   logic             rdy_q, rdy_d;
   logic             sout_q, sout_d;
   logic             vld_q, vld_d;
   logic             fs_q, fs_d;
   logic             end_frame;

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      count_d   = count_q;
      gap_d     = gap_q;
      par_d     = par_q;
      rdy_d     = rdy_q;
      sout_d    = sout_q;
      vld_d     = vld_q;
      fs_d      = 1'b0;
      end_frame = 1'b0;

      case (state_q)
         IDLE: begin
            rdy_d  = 1'b1;
            sout_d = 1'b0;
            vld_d  = 1'b0;
            if (Din_valid && rdy_q) begin
               state_d = SHIFT;
               rdy_d   = 1'b0;
               vld_d   = 1'b1;
               fs_d    = 1'b1;
               count_d = CW'(1);
               // Parity is captured at accept so later Din changes cannot leak in.
               par_d   = (^Din) ^ (PARITY_ODD != 0);
               if (MSB_FIRST != 0) begin
                  sout_d = Din[WIDTH-1];
                  sreg_d = Din << 1;
               end else begin
                  sout_d = Din[0];
                  sreg_d = Din >> 1;
               end
            end
         end
         SHIFT: begin
            if (count_q < CW'(WIDTH)) begin
               count_d = count_q + CW'(1);
               if (MSB_FIRST != 0) begin
                  sout_d = sreg_q[WIDTH-1];
                  sreg_d = sreg_q << 1;
               end else begin
                  sout_d = sreg_q[0];
                  sreg_d = sreg_q >> 1;
               end
            end else if (PARITY_EN != 0) begin
               state_d = PARITY;
               sout_d  = par_q;
               vld_d   = 1'b1;
            end else begin
               end_frame = 1'b1;
            end
         end
         PARITY: end_frame = 1'b1;
         GAP: begin
            sout_d = 1'b0;
            vld_d  = 1'b0;
            if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
               rdy_d   = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (end_frame) begin
         sout_d = 1'b0;
         vld_d  = 1'b0;
         if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
         end else begin
            state_d = IDLE;
            rdy_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         count_q <= '0;
         gap_q   <= '0;
         par_q   <= 1'b0;
         rdy_q   <= 1'b0;
         sout_q  <= 1'b0;
         vld_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         count_q <= count_d;
         gap_q   <= gap_d;
         par_q   <= par_d;
         rdy_q   <= rdy_d;
         sout_q  <= sout_d;
         vld_q   <= vld_d;
         fs_q    <= fs_d;
      end
   end

   assign Din_ready   = rdy_q;
   assign Sout        = sout_q;
   assign Sout_valid  = vld_q;
   assign Frame_start = fs_q;
   assign Busy        = (state_q != IDLE);

endmodule
